// File: rtl/dpll_lock_detect.sv
// ---------------------------------------------------------------------------
// dpll_lock_detect
// Lock detector for the DPLL. Each PFD up/down pulse is qualified against a
// width tolerance. Lock is declared after LOCK_CYCLES clean cycles, and it is
// dropped after UNLOCK_ERRORS violations inside one WIN_CYCLES window.
// Optional feature macro: DPLL_LOCK_STICKY_EN. When it is defined, the
// lol_sticky flag is built. It is set on every loss of lock that is caused by
// violations.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module dpll_lock_detect #(
  parameter int LOCK_CYCLES   = 64,
  parameter int TOL           = 2,
  parameter int UNLOCK_ERRORS = 4,
  parameter int WIN_CYCLES    = 256,
  parameter int CNT_W         = 8
) (
  input  logic             pll_clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             up,
  input  logic             down,
  output logic             locked,
  output logic [1:0]       state,
  output logic             viol,
  output logic [CNT_W-1:0] slip_cnt,
  output logic             lol_sticky
);

  localparam int GOOD_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int WIN_W  = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam int ERR_W  = $clog2(UNLOCK_ERRORS + 1);

  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CYCLES - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_CYCLES - 1);
  localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'(UNLOCK_ERRORS - 1);
  localparam logic [CNT_W-1:0]  RUN_TOL   = CNT_W'(TOL);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_WARN     = 2'd3
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  run_len;
  logic [GOOD_W-1:0] good_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [ERR_W-1:0]  err_cnt;

  logic              err_act;
  logic              violation;
  logic              win_wrap;
  logic [ERR_W-1:0]  err_base;
  logic              in_lock;
  logic              lock_loss;

  // An overlap of up and down counts as activity. A pulse violates exactly
  // once, on the cycle where its length goes past TOL.
  assign err_act   = up | down;
  assign violation = err_act && (run_len == RUN_TOL);
  assign win_wrap  = (win_cnt == WIN_LAST);
  // The window clear takes effect before a violation in the same cycle is counted.
  assign err_base  = win_wrap ? '0 : err_cnt;
  assign in_lock   = (state_q == ST_LOCKED) || (state_q == ST_WARN);
  assign lock_loss = in_lock && violation && (err_base == ERR_LAST);
  assign state     = state_q;

  // Measure the length of the current up|down pulse. The count saturates.
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      run_len <= '0;
    end else if (clear) begin
      run_len <= '0;
    end else if (err_act) begin
      run_len <= (run_len == CNT_MAX) ? run_len : run_len + 1'b1;
    end else begin
      run_len <= '0;
    end
  end

  // Lock FSM, with registered locked and viol outputs.
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_UNLOCKED;
      locked   <= 1'b0;
      viol     <= 1'b0;
      good_cnt <= '0;
      win_cnt  <= '0;
      err_cnt  <= '0;
    end else if (clear) begin
      state_q  <= ST_UNLOCKED;
      locked   <= 1'b0;
      viol     <= 1'b0;
      good_cnt <= '0;
      win_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      viol <= violation;
      case (state_q)
        ST_UNLOCKED: begin
          if (!err_act) begin
            state_q  <= ST_ACQUIRE;
            good_cnt <= '0;
          end
        end
        ST_ACQUIRE: begin
          if (violation) begin
            state_q  <= ST_UNLOCKED;
            good_cnt <= '0;
          end else if (good_cnt == GOOD_LAST) begin
            state_q <= ST_LOCKED;
            locked  <= 1'b1;
            win_cnt <= '0;
            err_cnt <= '0;
          end else begin
            good_cnt <= good_cnt + 1'b1;
          end
        end
        default: begin
          // ST_LOCKED and ST_WARN share the sliding-window bookkeeping.
          win_cnt <= win_wrap ? '0 : win_cnt + 1'b1;
          if (lock_loss) begin
            state_q  <= ST_UNLOCKED;
            locked   <= 1'b0;
            good_cnt <= '0;
            err_cnt  <= '0;
          end else if (violation) begin
            state_q <= ST_WARN;
            err_cnt <= err_base + 1'b1;
          end else begin
            err_cnt <= err_base;
            if (win_wrap) begin
              state_q <= ST_LOCKED;
            end
          end
        end
      endcase
    end
  end

  // Count the losses of lock caused by violations. The count saturates.
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      slip_cnt <= '0;
    end else if (clear) begin
      slip_cnt <= '0;
    end else if (lock_loss && (slip_cnt != CNT_MAX)) begin
      slip_cnt <= slip_cnt + 1'b1;
    end
  end

`ifdef DPLL_LOCK_STICKY_EN
  // Remember any loss of lock caused by violations until clear or reset.
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      lol_sticky <= 1'b0;
    end else if (clear) begin
      lol_sticky <= 1'b0;
    end else if (lock_loss) begin
      lol_sticky <= 1'b1;
    end
  end
`else
  assign lol_sticky = 1'b0;
`endif

endmodule

`default_nettype wire
